ped_leds_multi: RTL and testbench

PED_LEDS_MULTI -- requirements
Module: ped_leds_multi

---
 rtl/ped_leds_multi_if.sv | 13 +
 rtl/ped_leds_multi.sv | 128 ++++++++++++
 tb/tb_ped_leds_multi.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ped_leds_multi_if.sv
// Command/lamp bundle between a pedestrian-light controller and its user.
// The master drives enable and per-channel modes; the slave returns lamps and done pulses.
interface ped_leds_multi_if #(
  parameter int N_CH = 2
);
  logic                en;
  logic [2*N_CH-1:0]   mode;
  logic [2*N_CH-1:0]   led;
  logic [N_CH-1:0]     done;

  modport master (output en, output mode, input led, input done);
  modport slave  (input en, input mode, output led, output done);
endinterface

// File: rtl/ped_leds_multi.sv
// Multi-channel pedestrian light driver: steady green/red/test lamps or a blinking green
// with a done pulse every N_BLINK blink periods. Channels are fully independent.
module ped_leds_multi #(
  parameter int N_CH      = 2,
  parameter int BLINK_DIV = 1,
  parameter int N_BLINK   = 4
) (
  input  logic clk,
  input  logic rst,
  ped_leds_multi_if.slave ctl
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = (N_BLINK > 1) ? $clog2(N_BLINK) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(N_BLINK - 1);

  localparam logic [1:0] M_GREEN = 2'b00;
  localparam logic [1:0] M_BLINK = 2'b01;
  localparam logic [1:0] M_RED   = 2'b10;
  localparam logic [1:0] M_TEST  = 2'b11;

  logic [1:0]        prev_q  [N_CH];
  logic [1:0]        prev_d  [N_CH];
  logic [CW-1:0]     cnt_q   [N_CH];
  logic [CW-1:0]     cnt_d   [N_CH];
  logic [PW-1:0]     pcnt_q  [N_CH];
  logic [PW-1:0]     pcnt_d  [N_CH];
  logic [N_CH-1:0]   phase_q;
  logic [N_CH-1:0]   phase_d;
  logic [2*N_CH-1:0] led_q;
  logic [2*N_CH-1:0] led_d;
  logic [N_CH-1:0]   done_q;
  logic [N_CH-1:0]   done_d;

  // Lamp pattern {green, red} for the non-blinking commands.
  function automatic logic [1:0] steady_led(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      M_GREEN: r = 2'b10;
      M_RED:   r = 2'b01;
      M_TEST:  r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Per-channel next-state: enable gating, steady modes and the blink sequencer.
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    led_d   = led_q;
    done_d  = done_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!ctl.en) begin
        prev_d[i]       = M_RED;
        cnt_d[i]        = '0;
        pcnt_d[i]       = '0;
        phase_d[i]      = 1'b1;
        led_d[2*i +: 2] = 2'b00;
        done_d[i]       = 1'b0;
      end else begin
        prev_d[i] = ctl.mode[2*i +: 2];
        done_d[i] = 1'b0;
        case (ctl.mode[2*i +: 2])
          M_BLINK: begin
            if (prev_q[i] != M_BLINK) begin
              cnt_d[i]        = '0;
              pcnt_d[i]       = '0;
              phase_d[i]      = 1'b1;
              led_d[2*i +: 2] = 2'b10;
            end else if (cnt_q[i] != CNT_MAX) begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
              cnt_d[i]   = '0;
              phase_d[i] = ~phase_q[i];
              // A dark-to-lit edge closes one full blink period.
              if (phase_q[i] == 1'b0) begin
                led_d[2*i +: 2] = 2'b10;
                if (pcnt_q[i] == PCNT_MAX) begin
                  pcnt_d[i] = '0;
                  done_d[i] = 1'b1;
                end else begin
                  pcnt_d[i] = pcnt_q[i] + PW'(1);
                end
              end else begin
                led_d[2*i +: 2] = 2'b00;
              end
            end
          end
          default: begin
            cnt_d[i]        = '0;
            pcnt_d[i]       = '0;
            phase_d[i]      = 1'b1;
            led_d[2*i +: 2] = steady_led(ctl.mode[2*i +: 2]);
          end
        endcase
      end
    end
  end

  // State and output registers; reset leaves every channel dark with the next blink an entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        prev_q[i] <= M_RED;
        cnt_q[i]  <= '0;
        pcnt_q[i] <= '0;
      end
      phase_q <= '1;
      led_q   <= '0;
      done_q  <= '0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign ctl.led  = led_q;
  assign ctl.done = done_q;

endmodule

// File: tb/tb_ped_leds_multi.sv
// Directed bench: table of per-cycle vectors for BLINK_DIV=3/N_BLINK=2, plus a
// hand sequence for BLINK_DIV=1/N_BLINK=1 with a mid-cycle asynchronous reset.
module tb_ped_leds_multi;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mode;
    logic [3:0] exp_led;
    logic [1:0] exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ped_leds_multi_if #(.N_CH(2)) aif ();
  ped_leds_multi_if #(.N_CH(2)) bif ();

  ped_leds_multi #(.N_CH(2), .BLINK_DIV(3), .N_BLINK(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .ctl (aif)
  );

  ped_leds_multi #(.N_CH(2), .BLINK_DIV(1), .N_BLINK(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .ctl (bif)
  );

  task automatic check(input string name, input int step, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] m,
                              input logic [3:0] l, input logic [1:0] d);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.exp_led = l; v.exp_done = d;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [3:0] bl_led [4];
    logic [1:0] bl_done [4];
    logic [1:0] ch0;
    logic [1:0] ch1;

    aif.en = 1'b1; aif.mode = 4'b1001;
    bif.en = 1'b1; bif.mode = 4'b1001;

    // Reset state, then ch0 blinking from reset with ch1 red -> test at edge 5.
    vecs.push_back(mk(1'b0, 1'b1, 4'b1001, 4'b0000, 2'b00));
    for (int k = 1; k <= 26; k++) begin
      ch0 = ((((k - 1) / 3) % 2) == 0) ? 2'b10 : 2'b00;
      ch1 = (k < 5) ? 2'b01 : 2'b11;
      vecs.push_back(mk(1'b1, 1'b1, (k < 5) ? 4'b1001 : 4'b1101, {ch1, ch0},
                        (k == 13 || k == 25) ? 2'b01 : 2'b00));
    end
    // Leave blink at edge 4 for two cycles, then re-enter.
    vecs.push_back(mk(1'b0, 1'b1, 4'b1001, 4'b0000, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0100, 2'b00));
    // Enable dropped for two cycles mid-blink, then a fresh entry.
    vecs.push_back(mk(1'b0, 1'b1, 4'b1001, 4'b0000, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0100, 2'b00));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1001, 4'b0000, 2'b00));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1001, 4'b0000, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0100, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0100, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0100, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1001, 4'b0110, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_a    = vecs[i].rst;
      aif.en   = vecs[i].en;
      aif.mode = vecs[i].mode;
      @(posedge clk);
      #1;
      check("a_led", i, aif.led, vecs[i].exp_led);
      check("a_done", i, {2'b00, aif.done}, {2'b00, vecs[i].exp_done});
    end

    // Divide-by-one blink: toggle every cycle, done on every dark-to-lit edge.
    bl_led[0] = 4'b0110; bl_done[0] = 2'b00;
    bl_led[1] = 4'b0100; bl_done[1] = 2'b00;
    bl_led[2] = 4'b0110; bl_done[2] = 2'b01;
    bl_led[3] = 4'b0100; bl_done[3] = 2'b00;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        check("b_led", pass * 10 + k, bif.led, bl_led[k]);
        check("b_done", pass * 10 + k, {2'b00, bif.done}, {2'b00, bl_done[k]});
      end
      @(posedge clk);
      #1;
      check("b_led_pre_rst", pass, bif.led, 4'b0110);
      check("b_done_pre_rst", pass, {2'b00, bif.done}, 4'b0001);
      #2;
      rst_b = 1'b0;
      #1;
      check("b_led_async_rst", pass, bif.led, 4'b0000);
      check("b_done_async_rst", pass, {2'b00, bif.done}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
